// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, frame shape and baud divisor helper.
// The receiver uses the same package, so both ends agree on the bit period.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the transmitter; show-ahead output (dout is the head entry).
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_LEVEL);
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: byte FIFO in front of a start/data/stop serialiser.
// Handshake: a byte is taken on any rising edge with tx_valid && tx_ready; holding tx_valid while tx_ready is low stalls.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD),
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_t state, state_next;
    logic [CW-1:0] baud_cnt, baud_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic          line_next;
    logic          baud_last;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;

    assign tx_ready = !fifo_full;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_valid && tx_ready),
        .pop   (fifo_pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign baud_last = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            shift_reg <= '0;
            bit_idx   <= '0;
            uart_tx   <= 1'b1;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_cnt_next;
            shift_reg <= shift_next;
            bit_idx   <= bit_idx_next;
            uart_tx   <= line_next;
        end
    end

    // The line level is decoded from the current state and registered, so uart_tx trails the state by one cycle
    // uniformly across the whole frame; frame length and back-to-back spacing are unaffected.
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_last ? '0 : baud_cnt + CW'(1);
        shift_next    = shift_reg;
        bit_idx_next  = bit_idx;
        line_next     = 1'b1;
        fifo_pop      = 1'b0;
        case (state)
            IDLE: begin
                baud_cnt_next = '0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_dout;
                    state_next = START;
                end
            end
            START: begin
                line_next = 1'b0;
                if (baud_last) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                line_next = shift_reg[0];
                if (baud_last) begin
                    shift_next = shift_reg >> 1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        state_next   = STOP;
                        bit_idx_next = '0;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    if (bit_idx != 3'(STOP_BITS - 1)) begin
                        bit_idx_next = bit_idx + 3'd1;
                    end else if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_dout;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx_busy = (state != IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter at 10 clocks per bit: a line decoder acts as the receiver and checks
// every frame against the queue of accepted bytes; scenario tasks add cycle-exact checks.
module tb_uart_transmitter;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       uart_tx;
    logic       tx_busy;
    logic [2:0] fifo_level;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    int         rx_start_q[$];
    int         rx_count = 0;
    int         ncyc = 0;
    bit         mon_busy = 1'b0;
    int         mon_cnt = 0;
    int         mon_start = 0;
    logic [7:0] mon_byte = 8'h00;

    uart_transmitter #(
        .CLK_FREQ   (1000000),
        .BAUD       (100000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .fifo_level (fifo_level)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #600000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // line decoder: samples mid-bit, pops the expected queue at each stop bit
    initial forever begin
        @(negedge clk);
        ncyc++;
        if (!rst_n) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (uart_tx === 1'b0) begin
                mon_busy  = 1'b1;
                mon_cnt   = 0;
                mon_start = ncyc;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 5) begin
                n_checks++;
                if (uart_tx !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mon_start_bit: got %b want 0 at cycle %0d", uart_tx, ncyc);
                    mon_busy = 1'b0;
                end
            end else if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt - 5) % 10 == 0) begin
                mon_byte[(mon_cnt - 15) / 10] = uart_tx;
            end else if (mon_cnt == 95) begin
                n_checks++;
                if (uart_tx !== 1'b1) begin
                    n_fail++;
                    $display("FAIL mon_stop_bit: got %b want 1 at cycle %0d", uart_tx, ncyc);
                end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL mon_unexpected_frame: got %02h with nothing queued", mon_byte);
                end else begin
                    logic [7:0] exp_b;
                    exp_b = exp_q.pop_front();
                    if (mon_byte !== exp_b) begin
                        n_fail++;
                        $display("FAIL mon_data: got %02h want %02h", mon_byte, exp_b);
                    end
                end
                rx_count++;
                rx_start_q.push_back(mon_start);
                mon_busy = 1'b0;
            end
        end
    end

    // driver tasks
    task automatic push_byte(input logic [7:0] b);
        int w;
        w = 0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && w < 500) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (w >= 500) begin
            n_fail++;
            $display("FAIL push_timeout: tx_ready=%b want 1 within 500 cycles", tx_ready);
            tx_valid = 1'b0;
        end else begin
            exp_q.push_back(b);
            @(posedge clk);
        end
    endtask

    task automatic end_push();
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while ((exp_q.size() != 0 || mon_busy || tx_busy) && w < 5000);
        n_checks++;
        if (w >= 5000) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d bytes outstanding, tx_busy=%b want 0", exp_q.size(), tx_busy);
        end
        repeat (5) @(negedge clk);
    endtask

    // scenarios
    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_uart_tx: got %b want 1", uart_tx); end
        n_checks++;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        n_checks++;
        if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
        n_checks++;
        if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_level: got %0d want 0", fifo_level); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        push_byte(8'h3C);
        push_byte(8'h81);
        push_byte(8'h7E);
        end_push();
        repeat (40) @(negedge clk);
        n_checks++;
        if (tx_busy !== 1'b1 || fifo_level !== 3'd2) begin
            n_fail++;
            $display("FAIL midreset_pre: tx_busy=%b fifo_level=%0d want 1 and 2", tx_busy, fifo_level);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL midreset_uart_tx: got %b want 1", uart_tx); end
        n_checks++;
        if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_tx_busy: got %b want 0", tx_busy); end
        n_checks++;
        if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL midreset_fifo_level: got %0d want 0", fifo_level); end
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            n_checks++;
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle: uart_tx=%b tx_busy=%b want 1 and 0 at cycle %0d", uart_tx, tx_busy, k);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] pat;
        logic       exp_bit;
        pat = 8'hA5;
        push_byte(pat);
        for (int k = 1; k <= 103; k++) begin
            @(negedge clk);
            if (k == 1) tx_valid = 1'b0;
            if (k <= 2)       exp_bit = 1'b1;
            else if (k <= 12) exp_bit = 1'b0;
            else if (k <= 92) exp_bit = pat[(k - 13) / 10];
            else              exp_bit = 1'b1;
            n_checks++;
            if (uart_tx !== exp_bit) begin
                n_fail++;
                $display("FAIL single_line: got %b want %b at cycle %0d after accept", uart_tx, exp_bit, k);
            end
            if (k == 1) begin
                n_checks++;
                if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL single_level_after_push: got %0d want 1", fifo_level); end
            end
            if (k == 2) begin
                n_checks++;
                if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL single_level_after_pop: got %0d want 0", fifo_level); end
            end
            if (k == 50) begin
                n_checks++;
                if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_mid: got %b want 1", tx_busy); end
            end
            if (k == 103) begin
                n_checks++;
                if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", tx_busy); end
            end
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        rx_start_q.delete();
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h55);
        end_push();
        wait_drain();
        n_checks++;
        if (rx_start_q.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_frames: got %0d frames want 3", rx_start_q.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_checks++;
                if (rx_start_q[i] - rx_start_q[i-1] != 10 * CPB) begin
                    n_fail++;
                    $display("FAIL b2b_spacing: got %0d cycles want %0d", rx_start_q[i] - rx_start_q[i-1], 10 * CPB);
                end
            end
        end
    endtask

    task automatic test_full_fifo();
        int base;
        int max_level;
        bit saw_stall;
        base      = rx_count;
        max_level = 0;
        saw_stall = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) push_byte(8'hC0 + 8'(i));
                end_push();
            end
            begin
                for (int c = 0; c < 300; c++) begin
                    @(negedge clk);
                    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
                    if (tx_valid && !tx_ready) saw_stall = 1'b1;
                    n_checks++;
                    if (tx_ready !== (fifo_level != 3'd4)) begin
                        n_fail++;
                        $display("FAIL full_ready: tx_ready=%b with fifo_level=%0d", tx_ready, fifo_level);
                    end
                end
            end
        join
        wait_drain();
        n_checks++;
        if (max_level != 4) begin n_fail++; $display("FAIL full_max_level: got %0d want 4", max_level); end
        n_checks++;
        if (!saw_stall) begin n_fail++; $display("FAIL full_stall: got no stall want a stall"); end
        n_checks++;
        if (rx_count - base != 6) begin n_fail++; $display("FAIL full_count: got %0d frames want 6", rx_count - base); end
    endtask

    task automatic test_simul_push_pop();
        rx_start_q.delete();
        @(negedge clk);
        tx_data  = 8'h3A;
        tx_valid = 1'b1;
        exp_q.push_back(8'h3A);
        @(negedge clk);
        n_checks++;
        if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL simul_level_first: got %0d want 1", fifo_level); end
        tx_data = 8'hC5;
        exp_q.push_back(8'hC5);
        @(negedge clk);
        n_checks++;
        if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL simul_level_idle_pop: got %0d want 1", fifo_level); end
        tx_valid = 1'b0;
        repeat (99) @(negedge clk);
        n_checks++;
        if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL simul_level_before: got %0d want 1", fifo_level); end
        tx_data  = 8'h96;
        tx_valid = 1'b1;
        exp_q.push_back(8'h96);
        @(negedge clk);
        tx_valid = 1'b0;
        n_checks++;
        if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL simul_level_stop_pop: got %0d want 1", fifo_level); end
        wait_drain();
        n_checks++;
        if (rx_start_q.size() != 3) begin
            n_fail++;
            $display("FAIL simul_frames: got %0d frames want 3", rx_start_q.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_checks++;
                if (rx_start_q[i] - rx_start_q[i-1] != 10 * CPB) begin
                    n_fail++;
                    $display("FAIL simul_spacing: got %0d cycles want %0d", rx_start_q[i] - rx_start_q[i-1], 10 * CPB);
                end
            end
        end
    endtask

    task automatic test_loopback();
        int base;
        base = rx_count;
        for (int i = 0; i < 256; i++) push_byte(8'(i));
        end_push();
        wait_drain();
        n_checks++;
        if (rx_count - base != 256) begin
            n_fail++;
            $display("FAIL loopback_count: got %0d bytes want 256", rx_count - base);
        end
    endtask

    // sequence and report
    initial begin
        test_reset();
        test_reset_mid_frame();
        test_single();
        test_back_to_back();
        test_full_fifo();
        test_simul_push_pop();
        test_loopback();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: got %0d bytes outstanding want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
